// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates a valid/ready stream of products into per-group saturated sums
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic             r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic             w_count_full;

    assign w_accept     = in_valid && (r_state == ST_ACCUM);
    assign w_sum        = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign w_count_full = &r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (r_state == ST_HOLD) begin
            // Result stays frozen until the consumer takes it, then the group clears.
            if (out_ready) begin
                r_state <= ST_ACCUM;
                r_acc   <= '0;
                r_count <= '0;
                r_sat   <= 1'b0;
            end
        end else if (w_accept) begin
            // A saturated acc is all ones, so any further add overflows back to all ones.
            if (w_sum[ACC_W]) begin
                r_acc <= '1;
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            if (!w_count_full) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (in_last) begin
                r_state <= ST_HOLD;
            end
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized and directed self-checking bench for product_accumulator
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_product;
    logic       in_last;
    logic       out_ready;

    logic        a_rdy, a_vld, a_sat;
    logic [15:0] a_sum;
    logic [3:0]  a_cnt;
    logic        s_rdy, s_vld, s_sat;
    logic [9:0]  s_sum;
    logic [3:0]  s_cnt;
    logic        c_rdy, c_vld, c_sat;
    logic [15:0] c_sum;
    logic [1:0]  c_cnt;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference: a group is just a running total and a beat count plus a pending-result flag.
    longint m_total = 0;
    int     m_beats = 0;
    bit     m_pend  = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_rdy),
        .in_product(in_product), .in_last(in_last), .out_valid(a_vld),
        .out_ready(out_ready), .out_sum(a_sum), .out_count(a_cnt), .out_sat(a_sat));

    product_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_rdy),
        .in_product(in_product), .in_last(in_last), .out_valid(s_vld),
        .out_ready(out_ready), .out_sum(s_sum), .out_count(s_cnt), .out_sat(s_sat));

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_rdy),
        .in_product(in_product), .in_last(in_last), .out_valid(c_vld),
        .out_ready(out_ready), .out_sum(c_sum), .out_count(c_cnt), .out_sat(c_sat));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string name, input int accw, input int cntw,
                             input logic rdy, input logic vld, input logic [31:0] sum,
                             input logic [31:0] cnt, input logic sat);
        longint smax;
        int     cmax;
        smax = (64'd1 << accw) - 1;
        cmax = (1 << cntw) - 1;
        check({name, "_in_ready"},  {31'd0, rdy}, {31'd0, !m_pend});
        check({name, "_out_valid"}, {31'd0, vld}, {31'd0, m_pend});
        check({name, "_sum"},   sum, (m_total > smax) ? 32'(smax) : 32'(m_total));
        check({name, "_count"}, cnt, (m_beats > cmax) ? 32'(cmax) : 32'(m_beats));
        check({name, "_sat"},   {31'd0, sat}, {31'd0, m_total > smax});
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [7:0] p,
                         input logic l, input logic ordy);
        @(negedge clk);
        rst_n = rst; in_valid = v; in_product = p; in_last = l; out_ready = ordy;
        @(posedge clk);
        if (!rst) begin
            m_total = 0; m_beats = 0; m_pend = 0;
        end else if (m_pend) begin
            if (ordy) begin
                m_total = 0; m_beats = 0; m_pend = 0;
            end
        end else if (v) begin
            m_total += p;
            m_beats++;
            if (l) m_pend = 1;
        end
        #1;
        check_dut("a", 16, 4, a_rdy, a_vld, 32'(a_sum), 32'(a_cnt), a_sat);
        check_dut("s", 10, 4, s_rdy, s_vld, 32'(s_sum), 32'(s_cnt), s_sat);
        check_dut("c", 16, 2, c_rdy, c_vld, 32'(c_sum), 32'(c_cnt), c_sat);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b0;

        repeat (3) cycle(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        check("reset_sum", 32'(a_sum), 32'd0);

        cycle(1, 1, 81, 0, 0);
        cycle(1, 1, 225, 0, 0);
        cycle(1, 1, 0, 1, 0);
        check("grp_sum", 32'(a_sum), 32'd306);
        check("grp_count", 32'(a_cnt), 32'd3);
        cycle(1, 0, 0, 0, 1);
        check("grp_clear_ready", {31'd0, a_rdy}, 32'd1);

        repeat (4) cycle(1, 1, 225, 0, 0);
        cycle(1, 1, 225, 1, 0);
        check("sat_sum", 32'(s_sum), 32'd1023);
        check("sat_flag", {31'd0, s_sat}, 32'd1);
        check("sat_count", 32'(s_cnt), 32'd5);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 4, 1, 0);
        check("sat_next_sum", 32'(s_sum), 32'd4);
        cycle(1, 0, 0, 0, 1);

        cycle(1, 1, 20, 0, 0);
        cycle(1, 1, 30, 1, 0);
        repeat (6) begin
            cycle(1, 1, 9, 0, 0);
            check("bp_sum", 32'(a_sum), 32'd50);
        end
        cycle(1, 1, 9, 0, 1);
        cycle(1, 1, 9, 0, 0);
        check("bp_wait_accepted", 32'(a_cnt), 32'd1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 0, 0, 1);

        repeat (5) cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 1, 0);
        check("cnt_sat_count", 32'(c_cnt), 32'd3);
        check("cnt_sat_sum", 32'(c_sum), 32'd6);
        cycle(1, 0, 0, 0, 1);

        cycle(1, 1, 10, 0, 0);
        cycle(1, 1, 10, 0, 0);
        cycle(0, 1, 10, 0, 0);
        cycle(1, 1, 7, 1, 0);
        check("rst_mid_sum", 32'(a_sum), 32'd7);
        check("rst_mid_count", 32'(a_cnt), 32'd1);
        cycle(0, 0, 0, 0, 0);
        check("rst_hold_valid", {31'd0, a_vld}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
